// File: rtl/game_state_fsm.sv
// Game-flow controller: IDLE/PLAY/HIT/CLEAR/GAMEOVER/WIN sequencing, lives, level and freeze timing.
// Optional pause support is enabled by defining GAME_STATE_PAUSE_EN.
module game_state_fsm #(
  parameter int NUM_LEVELS         = 3,
  parameter int START_LIVES        = 3,
  parameter int HIT_FREEZE_TICKS   = 30,
  parameter int CLEAR_FREEZE_TICKS = 60
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       game_tick,
  input  logic       start_btn,
`ifdef GAME_STATE_PAUSE_EN
  input  logic       pause_btn,
`endif
  input  logic       hit_enemy,
  input  logic       hit_hazard,
  input  logic       goal_reached,
  output logic [1:0] level,
  output logic       freeze,
  output logic [2:0] lives,
  output logic       respawn,
  output logic       game_over,
  output logic       game_won,
  output logic [2:0] state_dbg
);

`ifdef GAME_STATE_PAUSE_EN
  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_PLAY     = 3'd1,
    ST_HIT      = 3'd2,
    ST_CLEAR    = 3'd3,
    ST_GAMEOVER = 3'd4,
    ST_WIN      = 3'd5,
    ST_PAUSE    = 3'd6
  } state_t;
`else
  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_PLAY     = 3'd1,
    ST_HIT      = 3'd2,
    ST_CLEAR    = 3'd3,
    ST_GAMEOVER = 3'd4,
    ST_WIN      = 3'd5
  } state_t;
`endif

  localparam logic [1:0] LAST_LEVEL  = 2'(NUM_LEVELS - 1);
  localparam logic [2:0] INIT_LIVES  = 3'(START_LIVES);
  localparam logic [7:0] HIT_TICKS   = 8'(HIT_FREEZE_TICKS);
  localparam logic [7:0] CLEAR_TICKS = 8'(CLEAR_FREEZE_TICKS);

  state_t     state_r, state_nx_s;
  logic [1:0] level_r, level_nx_s;
  logic [2:0] lives_r, lives_nx_s;
  logic [7:0] timer_r, timer_nx_s;
  logic       respawn_r, respawn_nx_s;
  logic       freeze_r, game_over_r, game_won_r;
  logic       start_q_r;
  logic       start_press_s;
  logic       hit_s;

  assign start_press_s = start_btn & ~start_q_r;
  assign hit_s         = hit_enemy | hit_hazard;

`ifdef GAME_STATE_PAUSE_EN
  logic pause_q_r;
  logic pause_press_s;

  assign pause_press_s = pause_btn & ~pause_q_r;

  // Pause button history for rising-edge detection
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pause_q_r <= 1'b0;
    end else begin
      pause_q_r <= pause_btn;
    end
  end
`endif

  // Next-state, counter and respawn decode
  always_comb begin
    state_nx_s   = state_r;
    level_nx_s   = level_r;
    lives_nx_s   = lives_r;
    timer_nx_s   = timer_r;
    respawn_nx_s = 1'b0;
    case (state_r)
      ST_IDLE, ST_GAMEOVER, ST_WIN: begin
        if (start_press_s) begin
          level_nx_s   = 2'd0;
          lives_nx_s   = INIT_LIVES;
          respawn_nx_s = 1'b1;
          state_nx_s   = ST_PLAY;
        end else begin
          state_nx_s = state_r;
        end
      end
      ST_PLAY: begin
        if (hit_s) begin
          // lives<=1 (not ==1) so a corrupted zero can never wrap to 7
          if (lives_r <= 3'd1) begin
            lives_nx_s = 3'd0;
            state_nx_s = ST_GAMEOVER;
          end else begin
            lives_nx_s = lives_r - 3'd1;
            timer_nx_s = HIT_TICKS;
            state_nx_s = ST_HIT;
          end
        end else if (goal_reached) begin
          timer_nx_s = CLEAR_TICKS;
          state_nx_s = ST_CLEAR;
        end
`ifdef GAME_STATE_PAUSE_EN
        else if (pause_press_s) begin
          state_nx_s = ST_PAUSE;
        end
`endif
        else begin
          state_nx_s = ST_PLAY;
        end
      end
      ST_HIT: begin
        if (game_tick) begin
          if (timer_r <= 8'd1) begin
            timer_nx_s   = 8'd0;
            respawn_nx_s = 1'b1;
            state_nx_s   = ST_PLAY;
          end else begin
            timer_nx_s = timer_r - 8'd1;
          end
        end else begin
          timer_nx_s = timer_r;
        end
      end
      ST_CLEAR: begin
        if (game_tick) begin
          if (timer_r <= 8'd1) begin
            timer_nx_s = 8'd0;
            if (level_r >= LAST_LEVEL) begin
              state_nx_s = ST_WIN;
            end else begin
              level_nx_s   = level_r + 2'd1;
              respawn_nx_s = 1'b1;
              state_nx_s   = ST_PLAY;
            end
          end else begin
            timer_nx_s = timer_r - 8'd1;
          end
        end else begin
          timer_nx_s = timer_r;
        end
      end
`ifdef GAME_STATE_PAUSE_EN
      ST_PAUSE: begin
        if (pause_press_s) begin
          state_nx_s = ST_PLAY;
        end else begin
          state_nx_s = ST_PAUSE;
        end
      end
`endif
      default: begin
        state_nx_s = ST_IDLE;
        level_nx_s = 2'd0;
        lives_nx_s = INIT_LIVES;
        timer_nx_s = 8'd0;
      end
    endcase
  end

  // State, counters and registered status outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r     <= ST_IDLE;
      level_r     <= 2'd0;
      lives_r     <= INIT_LIVES;
      timer_r     <= 8'd0;
      respawn_r   <= 1'b0;
      freeze_r    <= 1'b1;
      game_over_r <= 1'b0;
      game_won_r  <= 1'b0;
      start_q_r   <= 1'b0;
    end else begin
      state_r     <= state_nx_s;
      level_r     <= level_nx_s;
      lives_r     <= lives_nx_s;
      timer_r     <= timer_nx_s;
      respawn_r   <= respawn_nx_s;
      freeze_r    <= (state_nx_s != ST_PLAY);
      game_over_r <= (state_nx_s == ST_GAMEOVER);
      game_won_r  <= (state_nx_s == ST_WIN);
      start_q_r   <= start_btn;
    end
  end

  assign level     = level_r;
  assign lives     = lives_r;
  assign freeze    = freeze_r;
  assign respawn   = respawn_r;
  assign game_over = game_over_r;
  assign game_won  = game_won_r;
  assign state_dbg = state_r;

endmodule

// File: tb/tb_game_state_fsm.sv
// Self-checking bench for game_state_fsm: directed scenarios plus randomized traffic
// compared against a tick-counting behavioural model of the game rules.
module tb_game_state_fsm;
  localparam int NL = 3;
  localparam int SL = 3;
  localparam int HT = 30;
  localparam int CT = 60;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       game_tick = 1'b0;
  logic       start_btn = 1'b0;
  logic       hit_enemy = 1'b0;
  logic       hit_hazard = 1'b0;
  logic       goal_reached = 1'b0;
  logic [1:0] level;
  logic       freeze;
  logic [2:0] lives;
  logic       respawn;
  logic       game_over;
  logic       game_won;
  logic [2:0] state_dbg;

  int tests = 0;
  int fails = 0;

  // model: mode uses the documented state numbering, hold = game_ticks still to wait
  int m_mode, m_level, m_lives, m_hold;
  bit m_respawn, m_prev_start;
  int tick_gap = 0;

  game_state_fsm #(.NUM_LEVELS(NL), .START_LIVES(SL), .HIT_FREEZE_TICKS(HT),
                   .CLEAR_FREEZE_TICKS(CT)) dut (
    .clk(clk), .rst(rst), .game_tick(game_tick), .start_btn(start_btn),
    .hit_enemy(hit_enemy), .hit_hazard(hit_hazard), .goal_reached(goal_reached),
    .level(level), .freeze(freeze), .lives(lives), .respawn(respawn),
    .game_over(game_over), .game_won(game_won), .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  wire logic [11:0] dut_vec = {state_dbg, level, lives, freeze, respawn, game_over, game_won};

  function automatic logic [11:0] model_vec();
    return {3'(m_mode), 2'(m_level), 3'(m_lives), 1'(m_mode != 1), 1'(m_respawn),
            1'(m_mode == 4), 1'(m_mode == 5)};
  endfunction

  task automatic model_reset();
    m_mode = 0; m_level = 0; m_lives = SL; m_hold = 0; m_respawn = 0; m_prev_start = 0;
  endtask

  task automatic model_clock();
    bit press, hit;
    press = start_btn && !m_prev_start;
    m_prev_start = start_btn;
    hit = hit_enemy || hit_hazard;
    m_respawn = 0;
    if (m_mode == 0 || m_mode == 4 || m_mode == 5) begin
      if (press) begin
        m_mode = 1; m_level = 0; m_lives = SL; m_respawn = 1;
      end
    end else if (m_mode == 1) begin
      if (hit) begin
        m_lives = (m_lives > 0) ? m_lives - 1 : 0;
        if (m_lives == 0) m_mode = 4;
        else begin m_hold = HT; m_mode = 2; end
      end else if (goal_reached) begin
        m_hold = CT; m_mode = 3;
      end
    end else if (game_tick) begin
      m_hold = m_hold - 1;
      if (m_hold == 0) begin
        if (m_mode == 2) begin
          m_mode = 1; m_respawn = 1;
        end else if (m_level == NL - 1) begin
          m_mode = 5;
        end else begin
          m_level = m_level + 1; m_mode = 1; m_respawn = 1;
        end
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    if (rst) model_clock();
    else model_reset();
    #1;
    if (tick_gap == 0) begin
      game_tick = 1'b1;
      tick_gap = $urandom_range(1, 3);
    end else begin
      game_tick = 1'b0;
      tick_gap = tick_gap - 1;
    end
  endtask

  // steps until the DUT leaves state st, counting game_ticks consumed on the way
  task automatic wait_leave(input logic [2:0] st, input bit poke, output int ticks, output bit ok);
    ticks = 0;
    ok = 0;
    for (int i = 0; i < 2000; i++) begin
      bit tk;
      if (poke && i == 3) begin hit_enemy = 1'b1; hit_hazard = 1'b1; end
      tk = game_tick;
      step();
      hit_enemy = 1'b0;
      hit_hazard = 1'b0;
      if (tk) ticks++;
      if (state_dbg != st) begin ok = 1; break; end
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    model_reset();
    step(); step();
    tests++;
    if (dut_vec !== 12'b000_00_011_1_0_0_0) begin
      fails++; $display("FAIL reset_values: got %b required %b", dut_vec, 12'b000_00_011_1_0_0_0);
    end
    rst = 1'b1;
    step();
    tests++;
    if (dut_vec !== model_vec()) begin
      fails++; $display("FAIL idle_hold: got %b required %b", dut_vec, model_vec());
    end
  endtask

  task automatic test_start_hold();
    int pulses = 0;
    start_btn = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      if (respawn) pulses++;
    end
    start_btn = 1'b0;
    step();
    tests++;
    if (pulses != 1) begin
      fails++; $display("FAIL start_respawn_count: got %0d required 1", pulses);
    end
    tests++;
    if ({state_dbg, freeze, level, lives} !== {3'd1, 1'b0, 2'd0, 3'd3}) begin
      fails++; $display("FAIL start_play: state %0d freeze %0d level %0d lives %0d required 1 0 0 3",
                        state_dbg, freeze, level, lives);
    end
  endtask

  task automatic test_hit();
    int ticks;
    bit ok;
    hit_enemy = 1'b1;
    step();
    hit_enemy = 1'b0;
    tests++;
    if ({state_dbg, lives, freeze} !== {3'd2, 3'd2, 1'b1}) begin
      fails++; $display("FAIL hit_entry: state %0d lives %0d freeze %0d required 2 2 1",
                        state_dbg, lives, freeze);
    end
    wait_leave(3'd2, 1'b1, ticks, ok);
    tests++;
    if (!ok || ticks != HT) begin
      fails++; $display("FAIL hit_freeze_ticks: got %0d (exited %0d) required %0d", ticks, ok, HT);
    end
    tests++;
    if ({respawn, freeze, lives} !== {1'b1, 1'b0, 3'd2}) begin
      fails++; $display("FAIL hit_exit: respawn %0d freeze %0d lives %0d required 1 0 2",
                        respawn, freeze, lives);
    end
    step();
    tests++;
    if (respawn !== 1'b0) begin
      fails++; $display("FAIL respawn_width: got %0d required 0", respawn);
    end
  endtask

  task automatic test_gameover();
    int ticks;
    bit ok;
    hit_hazard = 1'b1;
    step();
    hit_hazard = 1'b0;
    wait_leave(3'd2, 1'b0, ticks, ok);
    tests++;
    if (!ok || lives !== 3'd1) begin
      fails++; $display("FAIL second_hit: lives %0d exited %0d required 1 1", lives, ok);
    end
    hit_hazard = 1'b1;
    step(); step(); step();
    hit_hazard = 1'b0;
    tests++;
    if ({lives, game_over, freeze, state_dbg} !== {3'd0, 1'b1, 1'b1, 3'd4}) begin
      fails++; $display("FAIL gameover: lives %0d game_over %0d freeze %0d state %0d required 0 1 1 4",
                        lives, game_over, freeze, state_dbg);
    end
    start_btn = 1'b1;
    step();
    tests++;
    if ({lives, level, game_over, respawn, state_dbg} !== {3'd3, 2'd0, 1'b0, 1'b1, 3'd1}) begin
      fails++; $display("FAIL restart: lives %0d level %0d game_over %0d respawn %0d state %0d required 3 0 0 1 1",
                        lives, level, game_over, respawn, state_dbg);
    end
    step();
    start_btn = 1'b0;
    tests++;
    if (dut_vec !== model_vec()) begin
      fails++; $display("FAIL restart_settle: got %b required %b", dut_vec, model_vec());
    end
  endtask

  task automatic test_clear();
    int ticks;
    bit ok;
    for (int lv = 0; lv < NL; lv++) begin
      goal_reached = 1'b1;
      step();
      goal_reached = 1'b0;
      tests++;
      if ({state_dbg, freeze} !== {3'd3, 1'b1}) begin
        fails++; $display("FAIL clear_entry: level %0d state %0d freeze %0d required 3 1", lv, state_dbg, freeze);
      end
      wait_leave(3'd3, 1'b0, ticks, ok);
      tests++;
      if (!ok || ticks != CT) begin
        fails++; $display("FAIL clear_ticks: level %0d got %0d required %0d", lv, ticks, CT);
      end
      tests++;
      if (lv < NL - 1) begin
        if ({level, respawn, state_dbg} !== {2'(lv + 1), 1'b1, 3'd1}) begin
          fails++; $display("FAIL level_up: level %0d respawn %0d state %0d required %0d 1 1",
                            level, respawn, state_dbg, lv + 1);
        end
      end else begin
        if ({level, respawn, game_won, state_dbg} !== {2'd2, 1'b0, 1'b1, 3'd5}) begin
          fails++; $display("FAIL win: level %0d respawn %0d game_won %0d state %0d required 2 0 1 5",
                            level, respawn, game_won, state_dbg);
        end
      end
    end
    goal_reached = 1'b1;
    for (int i = 0; i < 20; i++) step();
    goal_reached = 1'b0;
    tests++;
    if ({level, game_won} !== {2'd2, 1'b1}) begin
      fails++; $display("FAIL win_hold: level %0d game_won %0d required 2 1", level, game_won);
    end
    start_btn = 1'b1;
    step();
    start_btn = 1'b0;
    step();
    tests++;
    if (dut_vec !== model_vec() || state_dbg !== 3'd1 || game_won !== 1'b0) begin
      fails++; $display("FAIL win_restart: got %b required %b", dut_vec, model_vec());
    end
  endtask

  task automatic test_simultaneous();
    int ticks;
    bit ok;
    goal_reached = 1'b1;
    hit_enemy = 1'b1;
    step();
    goal_reached = 1'b0;
    hit_enemy = 1'b0;
    tests++;
    if ({state_dbg, lives, level} !== {3'd2, 3'd2, 2'd0}) begin
      fails++; $display("FAIL hit_beats_goal: state %0d lives %0d level %0d required 2 2 0",
                        state_dbg, lives, level);
    end
    wait_leave(3'd2, 1'b0, ticks, ok);
  endtask

  task automatic test_reset_mid_clear();
    int guard = 0;
    int pulses = 0;
    goal_reached = 1'b1;
    step();
    goal_reached = 1'b0;
    while (m_hold != 10 && guard < 1000) begin step(); guard++; end
    tests++;
    if (guard >= 1000 || state_dbg !== 3'd3) begin
      fails++; $display("FAIL reach_clear_10: state %0d hold %0d required 3 10", state_dbg, m_hold);
    end
    rst = 1'b0;
    model_reset();
    #1;
    tests++;
    if (dut_vec !== 12'b000_00_011_1_0_0_0) begin
      fails++; $display("FAIL async_reset: got %b required %b", dut_vec, 12'b000_00_011_1_0_0_0);
    end
    step(); step();
    rst = 1'b1;
    for (int i = 0; i < 250; i++) begin
      step();
      if (respawn) pulses++;
    end
    tests++;
    if ({state_dbg, level, lives} !== {3'd0, 2'd0, 3'd3} || pulses != 0) begin
      fails++; $display("FAIL post_reset_idle: state %0d level %0d lives %0d pulses %0d required 0 0 3 0",
                        state_dbg, level, lives, pulses);
    end
  endtask

  task automatic test_random();
    int bad = 0;
    for (int i = 0; i < 4000; i++) begin
      hit_enemy    = ($urandom_range(0, 59) == 0);
      hit_hazard   = ($urandom_range(0, 89) == 0);
      goal_reached = ($urandom_range(0, 49) == 0);
      if ($urandom_range(0, 9) == 0) start_btn = ~start_btn;
      if ($urandom_range(0, 1499) == 0 && rst) begin
        rst = 1'b0;
        model_reset();
      end else begin
        rst = 1'b1;
      end
      step();
      tests++;
      if (dut_vec !== model_vec()) begin
        fails++; bad++;
        if (bad <= 10) $display("FAIL random_cycle %0d: got %b required %b", i, dut_vec, model_vec());
      end
    end
    hit_enemy = 1'b0; hit_hazard = 1'b0; goal_reached = 1'b0; start_btn = 1'b0; rst = 1'b1;
  endtask

  initial begin
    test_reset();
    test_start_hold();
    test_hit();
    test_gameover();
    test_clear();
    test_simultaneous();
    test_reset_mid_clear();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/game_state_fsm.md
Name: game_state_fsm

Overview:
- Top-level game-flow controller that sits directly downstream of the enemy/projectile controller.
- Consumes its `hit_enemy` collision flag, plus the hazard and goal flags from the player/terrain logic.
- Produces the `level` and `freeze` signals that the enemy controller and the player physics consume, and the lives, respawn and end-of-game status shown on the HUD.
- Time-based holds are counted in `game_tick` units, not clock cycles.

Parameters:
- NUM_LEVELS, 3, number of playable levels; `level` runs 0..NUM_LEVELS-1 (max 4).
- START_LIVES, 3, lives loaded on reset and on every new game (1..7).
- HIT_FREEZE_TICKS, 30, game_ticks the game stays frozen after losing a life (1..255).
- CLEAR_FREEZE_TICKS, 60, game_ticks the game stays frozen after a level is cleared (1..255).

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous active-low reset.
- game_tick  in  1  one-clk-wide frame strobe.
- start_btn  in  1  debounced start button, level-sensitive.
- hit_enemy  in  1  player touched the enemy or a projectile (combinational from the enemy controller).
- hit_hazard  in  1  player touched a level hazard or fell off the screen.
- goal_reached  in  1  player overlaps the level goal.
- level  out  2  current level index.
- freeze  out  1  high stalls all gameplay movement.
- lives  out  3  remaining lives.
- respawn  out  1  one-clk pulse telling the player controller to reload its spawn position.
- game_over  out  1  high while in the GAMEOVER state.
- game_won  out  1  high while in the WIN state.
- state_dbg  out  3  current state encoding, for LEDs.

Behaviour:
- Reset (async, rst=0) values:
  - state = IDLE, level = 0, lives = START_LIVES, freeze = 1.
  - respawn = 0, game_over = 0, game_won = 0.
  - timer = 0, start_btn history register = 0.
- Reset asserted mid-game aborts any state immediately, with no respawn pulse.
- start_press = start_btn & ~start_q, where start_q is start_btn registered every clk. Only a rising edge is a press; a held button does not retrigger.
- hit = hit_enemy | hit_hazard, sampled on every clk (not only on game_tick).
- State encoding: IDLE=0, PLAY=1, HIT=2, CLEAR=3, GAMEOVER=4, WIN=5.
- freeze = 1 in every state except PLAY. All outputs are registered.
- The 8-bit timer is loaded on entry to HIT or CLEAR. On a game_tick:
  - if timer==1, the FSM exits the state;
  - otherwise timer decrements.
  - This gives exactly N game_ticks of hold.
- IDLE:
  - start_press leads to PLAY.
  - level = 0, lives = START_LIVES, respawn pulses.
- PLAY:
  - If hit:
    - lives==1: lives = 0, go to GAMEOVER.
    - otherwise: lives decrements, timer = HIT_FREEZE_TICKS, go to HIT.
  - Else if goal_reached: timer = CLEAR_FREEZE_TICKS, go to CLEAR.
  - Simultaneous hit and goal_reached: hit wins.
  - start_press is ignored.
- HIT:
  - Inputs are ignored; no further life can be lost while frozen.
  - On timer expiry: respawn pulses, go to PLAY.
- CLEAR:
  - On timer expiry with level==NUM_LEVELS-1: go to WIN; level holds.
  - On timer expiry otherwise: level increments, respawn pulses, go to PLAY.
  - hit in CLEAR is ignored.
- GAMEOVER / WIN:
  - game_over and game_won are high in GAMEOVER and WIN respectively.
  - start_press: level = 0, lives = START_LIVES, respawn pulses, go to PLAY.
  - The output flag clears on the same edge as the transition.
- respawn is high for exactly one clk, on the edge where PLAY is entered. It never fires on the PLAY-to-PLAY path.
- A game_tick in the same clk as a hit in PLAY has no extra effect; the timer starts counting from the next game_tick.
- lives never underflows: it saturates at 0 in GAMEOVER.
- level never exceeds NUM_LEVELS-1.

Optional Feature:
GAME_STATE_PAUSE_EN
- Defined:
  - Adds input port pause_btn (1 bit), with rising-edge detection identical to start_btn.
  - Adds state PAUSE=6, in which freeze=1.
  - A press in PLAY goes to PAUSE; a press in PAUSE returns to PLAY with no respawn.
  - Hits and goal are ignored while in PAUSE.
  - In the edge where both apply, a pause press in PLAY has lower priority than hit and goal.
- Undefined:
  - No pause_btn port and no PAUSE state; behaviour is exactly as described above.

Test Plan:
- Reset, then hold start_btn high for 5 clks:
  - one respawn pulse only; state_dbg=1, freeze=0, level=0, lives=3.
- In PLAY, pulse hit_enemy for one clk:
  - lives=2, freeze=1 for exactly 30 game_ticks;
  - then a respawn pulse and freeze=0;
  - a second hit during the freeze leaves lives at 2.
- From PLAY with lives=1, assert hit_hazard:
  - lives=0, game_over=1, freeze=1;
  - a start_btn edge restores lives=3, level=0, game_over=0, with one respawn pulse.
- goal_reached at level 0:
  - CLEAR for 60 game_ticks, then level=1 and a respawn pulse;
  - repeat at level 2: game_won=1 and level stays 2.
- Assert goal_reached and hit_enemy in the same clk with lives=3:
  - enters HIT, lives=2, level unchanged.
- Drop rst to 0 while in CLEAR with the timer at 10:
  - immediately state=0, level=0, lives=3, freeze=1, respawn=0;
  - no spurious level increment after release.
